// File: rtl/mod4051_pkg.sv
// Shared constants and types for the modulus-4051 chunk residue engine.
package mod4051_pkg;

    localparam int unsigned MODULUS  = 4051;
    localparam int unsigned RES_W    = 12;
    localparam int unsigned CHUNK_W  = 6;
    localparam int unsigned FOLD_K   = 45;    // 2^12 mod 4051
    localparam int unsigned N_CHUNKS = 67;
    localparam int unsigned IDX_W    = 7;

    typedef logic [RES_W-1:0] res_t;
    typedef logic [17:0]      prod_t;

    typedef enum logic [1:0] {
        StAccum,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/mod4051_fold18.sv
// Combinational reduction of an 18-bit value to its residue mod 4051.
module mod4051_fold18
    import mod4051_pkg::*;
(
    input  prod_t prod,
    output res_t  res
);

    logic [12:0] q;

    // High six bits carry weight 2^12, which is congruent to FOLD_K; q <= 6930 < 2M.
    always_comb begin
        q = 13'(prod[17:12]) * 13'(FOLD_K) + 13'(prod[11:0]);
        if (q >= 13'(MODULUS)) begin
            res = res_t'(q - 13'(MODULUS));
        end else begin
            res = res_t'(q);
        end
    end

endmodule

// File: rtl/mod4051_chunk_accumulator.sv
// Streams 6-bit chunks LSB-first, weights each by 2^(6k) mod 4051 and accumulates the residue.
module mod4051_chunk_accumulator
    import mod4051_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] in_chunk,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RES_W-1:0]   out_res,
    output logic               out_ovf
);

    state_e           state;
    res_t             w;
    res_t             acc;
    logic [IDX_W-1:0] idx;
    prod_t            s1_prod;
    logic             s1_vld;
    logic             s1_last;
    logic             ovf;

    res_t             w_next;
    res_t             prod_red;
    logic [RES_W:0]   acc_sum;
    res_t             acc_next;
    logic             in_fire;
    logic             out_fire;
    logic             idx_end;

    mod4051_fold18 u_fold_w (
        .prod ({w, 6'b0}),
        .res  (w_next)
    );

    mod4051_fold18 u_fold_p (
        .prod (s1_prod),
        .res  (prod_red)
    );

    always_comb begin
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
        idx_end  = (idx == IDX_W'(N_CHUNKS - 1));
        acc_sum  = {1'b0, acc} + {1'b0, prod_red};
        if (acc_sum >= (RES_W + 1)'(MODULUS)) begin
            acc_next = res_t'(acc_sum - (RES_W + 1)'(MODULUS));
        end else begin
            acc_next = res_t'(acc_sum);
        end
    end

    assign out_res = acc;
    assign out_ovf = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StAccum;
            w         <= res_t'(1);
            acc       <= '0;
            idx       <= '0;
            s1_prod   <= '0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            s1_vld <= in_fire;
            if (in_fire) begin
                s1_prod <= prod_t'(in_chunk) * prod_t'(w);
                s1_last <= in_last | idx_end;
            end
            if (s1_vld) begin
                acc <= acc_next;
            end

            case (state)
                StAccum: begin
                    if (in_fire) begin
                        w   <= w_next;
                        idx <= idx + IDX_W'(1);
                        if (in_last || idx_end) begin
                            state    <= StDrain;
                            in_ready <= 1'b0;
                            ovf      <= ~in_last;
                        end
                    end
                end
                StDrain: begin
                    // The final product is folded into acc on this same edge.
                    if (s1_vld && s1_last) begin
                        state     <= StDone;
                        out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_fire) begin
                        acc       <= '0;
                        w         <= res_t'(1);
                        idx       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StAccum;
                    end
                end
                default: state <= StAccum;
            endcase
        end
    end

endmodule

// File: tb/tb_mod4051_chunk_accumulator.sv
// Scoreboard bench for the mod-4051 chunk accumulator; golden model uses MSB-first Horner reduction.
module tb_mod4051_chunk_accumulator;

    localparam int M = 4051;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_chunk = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_res;
    logic        out_ovf;

    typedef struct {
        int res;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   ready_rand = 1'b0;

    always #5 clk = ~clk;

    mod4051_chunk_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_chunk  (in_chunk),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int horner(input int ch[$]);
        int r = 0;
        for (int i = ch.size() - 1; i >= 0; i--) begin
            r = (r * 64 + ch[i]) % M;
        end
        return r;
    endfunction

    function automatic void push_exp(input int res, input bit ovf);
        exp_t e;
        e.res = res;
        e.ovf = ovf;
        exp_q.push_back(e);
    endfunction

    // Output monitor: pops the scoreboard on every residue transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", 32'(out_res), 32'hffff_ffff);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("sb_res", 32'(out_res), 32'(e.res));
                check_eq("sb_ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Called and returns at posedge+1; leaves in_valid low after the transfer edge.
    task automatic send_chunk(input logic [5:0] c, input logic l);
        int t;
        bit ok;
        in_valid = 1'b1;
        in_chunk = c;
        in_last  = l;
        ok = 1'b0;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("in_ready_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_operand(input int ch[$], input bit gaps);
        for (int i = 0; i < ch.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_chunk(6'(ch[i]), i == ch.size() - 1);
        end
    endtask

    task automatic wait_out(input string tag);
        bit ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq(tag, 32'(0), 32'(1));
    endtask

    task automatic drain_sb();
        for (int t = 0; t < 3000 && exp_q.size() > 0; t++) @(posedge clk);
        check_eq("sb_empty", 32'(exp_q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ch[$];
        int p;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'(1));
        check_eq("rst_out_valid", 32'(out_valid), 32'(0));
        check_eq("rst_out_res", 32'(out_res), 32'(0));
        check_eq("rst_out_ovf", 32'(out_ovf), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single chunk: out_valid must appear exactly two cycles after acceptance.
        push_exp(63, 1'b0);
        send_chunk(6'd63, 1'b1);
        @(negedge clk);
        check_eq("t1_valid_early", 32'(out_valid), 32'(0));
        @(negedge clk);
        check_eq("t1_valid_t2", 32'(out_valid), 32'(1));
        check_eq("t1_res", 32'(out_res), 32'(63));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain_sb();

        ch = '{1, 1};
        push_exp(65, 1'b0);
        send_operand(ch, 1'b0);
        ch = '{0, 0, 1};
        push_exp(45, 1'b0);
        send_operand(ch, 1'b0);
        ch = '{0, 0, 63};
        push_exp(2835, 1'b0);
        send_operand(ch, 1'b0);
        drain_sb();

        // Back-to-back with downstream stalled for five cycles.
        out_ready = 1'b0;
        push_exp(65, 1'b0);
        push_exp(45, 1'b0);
        send_chunk(6'd1, 1'b0);
        send_chunk(6'd1, 1'b1);
        in_valid = 1'b1;
        in_chunk = 6'd0;
        in_last  = 1'b0;
        wait_out("t3_out_timeout");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check_eq("t3_hold_valid", 32'(out_valid), 32'(1));
            check_eq("t3_hold_res", 32'(out_res), 32'(65));
            check_eq("t3_hold_in_ready", 32'(in_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_in_ready_at_xfer", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("t3_in_ready_after", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send_chunk(6'd0, 1'b0);
        send_chunk(6'd1, 1'b1);
        drain_sb();

        // 67 chunks of 63 with no last: (2^402 - 1) mod M with overflow flagged.
        p = 1;
        repeat (402) p = (p * 2) % M;
        push_exp((p + M - 1) % M, 1'b1);
        for (int i = 0; i < 67; i++) send_chunk(6'd63, 1'b0);
        drain_sb();

        ready_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            ch.delete();
            repeat ($urandom_range(1, 67)) ch.push_back(int'($urandom_range(0, 63)));
            push_exp(horner(ch), 1'b0);
            send_operand(ch, 1'b1);
        end
        drain_sb();
        ready_rand = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Reset mid-operand discards the partial accumulation.
        for (int i = 0; i < 10; i++) send_chunk(6'd7, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_in_ready", 32'(in_ready), 32'(1));
        check_eq("t6_out_valid", 32'(out_valid), 32'(0));
        check_eq("t6_out_res", 32'(out_res), 32'(0));
        check_eq("t6_out_ovf", 32'(out_ovf), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(5, 1'b0);
        send_chunk(6'd5, 1'b1);
        drain_sb();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
